// File: rtl/gate_test_sequencer_pkg.sv
// Shared definitions for the gate test sequencer.
// - state_e : controller state encoding (binary, 2 bits)
// - TT_*    : truth tables for common 2-input gates. Bit i is the expected output
//             for input vector i.
package gate_test_sequencer_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StApply = 2'd1,
    StDone  = 2'd2
  } state_e;

  localparam logic [3:0] TT_AND2  = 4'b1000;
  localparam logic [3:0] TT_OR2   = 4'b1110;
  localparam logic [3:0] TT_XOR2  = 4'b0110;
  localparam logic [3:0] TT_NAND2 = 4'b0111;

endpackage

// File: rtl/gate_test_sequencer_if.sv
// Bundle of the control, stimulus and result signals of the gate test sequencer.
// master : bench or board side. Drives start, abort and gate_s; observes the results.
// slave  : sequencer side.
interface gate_test_sequencer_if #(
  parameter int unsigned N_INPUTS = 2
) ();

  logic                start;
  logic                abort;
  logic                gate_s;
  logic [N_INPUTS-1:0] vec_out;
  logic                busy;
  logic                done;
  logic                pass;
  logic [N_INPUTS:0]   err_count;
  logic [N_INPUTS-1:0] fail_vec;
  logic                fail_valid;

  modport master (
    output start, abort, gate_s,
    input  vec_out, busy, done, pass, err_count, fail_vec, fail_valid
  );

  modport slave (
    input  start, abort, gate_s,
    output vec_out, busy, done, pass, err_count, fail_vec, fail_valid
  );

endinterface

// File: rtl/gate_test_sequencer_hold_timer.sv
// Counts the cycles that a stimulus vector has been held.
// Ports:
//   clk, rst_n : clock and asynchronous active-low reset
//   clr        : synchronous clear to 0. Takes priority over en.
//   en         : count. Wraps to 0 after HOLD_CYCLES-1.
//   last       : combinational. High when count == HOLD_CYCLES-1.
module gate_test_sequencer_hold_timer #(
  parameter int unsigned HOLD_CYCLES = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic last
);

  // Keep at least one bit so that HOLD_CYCLES == 1 still builds.
  localparam int unsigned CntW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(HOLD_CYCLES - 1);

  logic [CntW-1:0] cnt_q;

  assign last = (cnt_q == CntLast);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (clr) begin
      cnt_q <= '0;
    end else if (en) begin
      cnt_q <= last ? '0 : cnt_q + CntW'(1);
    end
  end

endmodule

// File: rtl/gate_test_sequencer.sv
// Self-checking stimulus controller for one combinational gate under test.
// A start drives every input vector in ascending order. Each vector is held for
// HOLD_CYCLES clocks, then gate_s is compared against EXPECTED[vector]. The run
// result is reported when the run completes.
// Ports:
//   clk, rst_n : clock and asynchronous active-low reset
//   bus        : slave modport
//     start, abort, gate_s                  : inputs
//     vec_out, busy, done, pass, err_count,
//     fail_vec, fail_valid                  : registered outputs
module gate_test_sequencer
  import gate_test_sequencer_pkg::*;
#(
  parameter int unsigned            N_INPUTS    = 2,
  parameter int unsigned            HOLD_CYCLES = 4,
  parameter logic [2**N_INPUTS-1:0] EXPECTED    = TT_AND2
) (
  input logic                  clk,
  input logic                  rst_n,
  gate_test_sequencer_if.slave bus
);

  localparam logic [N_INPUTS-1:0] VecMax = '1;

  state_e              state_q;
  logic [N_INPUTS-1:0] vec_q;
  logic                busy_q;
  logic                done_q;
  logic                pass_q;
  logic [N_INPUTS:0]   err_q;
  logic [N_INPUTS-1:0] fail_vec_q;
  logic                fail_valid_q;

  logic hold_last;
  logic mismatch;

  // The counter is cleared outside APPLY and on abort, so every run starts
  // from a full hold period.
  gate_test_sequencer_hold_timer #(
    .HOLD_CYCLES (HOLD_CYCLES)
  ) u_hold_timer (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   ((state_q != StApply) || bus.abort),
    .en    (state_q == StApply),
    .last  (hold_last)
  );

  assign mismatch = (bus.gate_s != EXPECTED[vec_q]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      vec_q        <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      pass_q       <= 1'b0;
      err_q        <= '0;
      fail_vec_q   <= '0;
      fail_valid_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          vec_q <= '0;
          if (bus.start) begin
            state_q      <= StApply;
            busy_q       <= 1'b1;
            pass_q       <= 1'b0;
            err_q        <= '0;
            fail_vec_q   <= '0;
            fail_valid_q <= 1'b0;
          end
        end
        StApply: begin
          if (bus.abort) begin
            // Partial error results stay visible. No compare happens on this edge.
            state_q <= StIdle;
            busy_q  <= 1'b0;
            vec_q   <= '0;
          end else if (hold_last) begin
            if (mismatch) begin
              err_q <= err_q + (N_INPUTS+1)'(1);
              if (!fail_valid_q) begin
                fail_vec_q   <= vec_q;
                fail_valid_q <= 1'b1;
              end
            end
            if (vec_q == VecMax) begin
              state_q <= StDone;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              // Fold in the last compare so that pass is valid with done.
              pass_q  <= (err_q == '0) && !mismatch;
            end else begin
              vec_q <= vec_q + N_INPUTS'(1);
            end
          end
        end
        StDone: begin
          state_q <= StIdle;
          vec_q   <= '0;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.vec_out    = vec_q;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.pass       = pass_q;
  assign bus.err_count  = err_q;
  assign bus.fail_vec   = fail_vec_q;
  assign bus.fail_valid = fail_valid_q;

endmodule

// File: tb/tb_gate_test_sequencer.sv
module tb_gate_test_sequencer;
  import gate_test_sequencer_pkg::*;

  logic clk;
  logic rst_n;
  int   vectors;
  int   miscompares;

  // Bench-controlled gate for dut_a: an arbitrary 2-input function given by its truth table.
  logic [3:0] gut_tt;

  gate_test_sequencer_if #(.N_INPUTS(2)) bus_a ();
  gate_test_sequencer_if #(.N_INPUTS(2)) bus_o ();
  gate_test_sequencer_if #(.N_INPUTS(1)) bus_i ();

  assign bus_a.gate_s = gut_tt[bus_a.vec_out];
  assign bus_o.gate_s = &bus_o.vec_out;    // and_gate checked against the OR table
  assign bus_i.gate_s = ~bus_i.vec_out[0]; // inverter

  gate_test_sequencer dut_a (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_a)
  );

  gate_test_sequencer #(
    .EXPECTED (TT_OR2)
  ) dut_o (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_o)
  );

  gate_test_sequencer #(
    .N_INPUTS    (1),
    .HOLD_CYCLES (1),
    .EXPECTED    (2'b01)
  ) dut_i (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: walk every vector and record the run statistics.
  function automatic void model(input logic [15:0] gut, input logic [15:0] exp, input int nvec,
                                output int errs, output bit fvalid, output int fvec,
                                output bit ok);
    errs = 0;
    fvalid = 0;
    fvec = 0;
    for (int v = 0; v < nvec; v++) begin
      if (gut[v] != exp[v]) begin
        errs++;
        if (!fvalid) begin
          fvalid = 1;
          fvec = v;
        end
      end
    end
    ok = (errs == 0);
  endfunction

  // Run length in negedges from the start request to done: 2**N * HOLD + 1.
  function automatic int run_len(input int nvec, input int hold);
    return nvec * hold + 1;
  endfunction

  task automatic test_reset();
    rst_n = 1'b0;
    #3;
    vectors++;
    if ({bus_a.vec_out, bus_a.busy, bus_a.done, bus_a.pass, bus_a.err_count, bus_a.fail_vec,
         bus_a.fail_valid} !== 10'd0) begin
      miscompares++;
      $display("FAIL reset_a: outputs=%b want all zero", {bus_a.vec_out, bus_a.busy, bus_a.done,
               bus_a.pass, bus_a.err_count, bus_a.fail_vec, bus_a.fail_valid});
    end
    vectors++;
    if ({bus_i.vec_out, bus_i.busy, bus_i.done, bus_i.pass, bus_i.err_count, bus_i.fail_vec,
         bus_i.fail_valid} !== 7'd0) begin
      miscompares++;
      $display("FAIL reset_i: outputs=%b want all zero", {bus_i.vec_out, bus_i.busy, bus_i.done,
               bus_i.pass, bus_i.err_count, bus_i.fail_vec, bus_i.fail_valid});
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_and_run();
    bit         seq_ok;
    logic [1:0] vexp;
    gut_tt = TT_AND2;
    bus_a.start = 1'b1;
    seq_ok = 1;
    for (int i = 1; i <= 16; i++) begin
      @(negedge clk);
      bus_a.start = 1'b0;
      vexp = 2'((i - 1) / 4);
      if (bus_a.vec_out !== vexp || bus_a.busy !== 1'b1 || bus_a.done !== 1'b0) begin
        if (seq_ok)
          $display("FAIL and_seq cycle %0d: vec_out=%0d busy=%b done=%b want vec_out=%0d busy=1 done=0",
                   i, bus_a.vec_out, bus_a.busy, bus_a.done, vexp);
        seq_ok = 0;
      end
    end
    vectors++;
    if (!seq_ok) miscompares++;
    @(negedge clk);
    vectors++;
    if (bus_a.done !== 1'b1 || bus_a.busy !== 1'b0) begin
      miscompares++;
      $display("FAIL and_done17: done=%b busy=%b want done=1 busy=0", bus_a.done, bus_a.busy);
    end
    vectors++;
    if (bus_a.pass !== 1'b1 || bus_a.err_count !== 3'd0 || bus_a.fail_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL and_result: pass=%b err=%0d fail_valid=%b want pass=1 err=0 fail_valid=0",
               bus_a.pass, bus_a.err_count, bus_a.fail_valid);
    end
    @(negedge clk);
    vectors++;
    if (bus_a.done !== 1'b0 || bus_a.vec_out !== 2'd0 || bus_a.pass !== 1'b1) begin
      miscompares++;
      $display("FAIL and_after: done=%b vec_out=%0d pass=%b want done=0 vec_out=0 pass=1",
               bus_a.done, bus_a.vec_out, bus_a.pass);
    end
  endtask

  task automatic test_random();
    int errs, fvec, cyc;
    bit fvalid, ok;
    for (int it = 0; it < 10; it++) begin
      gut_tt = 4'($urandom);
      model({12'd0, gut_tt}, {12'd0, TT_AND2}, 4, errs, fvalid, fvec, ok);
      repeat ($urandom_range(0, 3)) @(negedge clk);
      bus_a.start = 1'b1;
      cyc = 0;
      while (bus_a.done !== 1'b1 && cyc < 40) begin
        @(negedge clk);
        bus_a.start = 1'b0;
        cyc++;
      end
      bus_a.start = 1'b0;
      vectors++;
      if (cyc != run_len(4, 4)) begin
        miscompares++;
        $display("FAIL rand_latency tt=%b: done after %0d cycles want %0d", gut_tt, cyc,
                 run_len(4, 4));
      end
      vectors++;
      if (bus_a.err_count !== 3'(errs) || bus_a.pass !== ok || bus_a.fail_valid !== fvalid ||
          (fvalid && bus_a.fail_vec !== 2'(fvec))) begin
        miscompares++;
        $display("FAIL rand_result tt=%b: err=%0d pass=%b fv=%b fvec=%0d want err=%0d pass=%b fv=%b fvec=%0d",
                 gut_tt, bus_a.err_count, bus_a.pass, bus_a.fail_valid, bus_a.fail_vec, errs, ok,
                 fvalid, fvec);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_abort();
    bit   done_seen;
    logic exp_err;
    gut_tt = 4'($urandom);
    exp_err = gut_tt[0]; // only vector 0 (expected 0) is compared before the abort edge
    done_seen = 0;
    bus_a.start = 1'b1;
    for (int i = 1; i <= 30; i++) begin
      @(negedge clk);
      bus_a.start = 1'b0;
      if (bus_a.done === 1'b1) done_seen = 1;
      if (i == 6) bus_a.abort = 1'b1;
      if (i == 7) begin
        bus_a.abort = 1'b0;
        vectors++;
        if (bus_a.busy !== 1'b0 || bus_a.vec_out !== 2'd0 || bus_a.pass !== 1'b0) begin
          miscompares++;
          $display("FAIL abort_state: busy=%b vec_out=%0d pass=%b want 0 0 0", bus_a.busy,
                   bus_a.vec_out, bus_a.pass);
        end
        vectors++;
        if (bus_a.err_count !== {2'd0, exp_err} || bus_a.fail_valid !== exp_err) begin
          miscompares++;
          $display("FAIL abort_partial tt=%b: err=%0d fail_valid=%b want err=%0d fail_valid=%b",
                   gut_tt, bus_a.err_count, bus_a.fail_valid, exp_err, exp_err);
        end
      end
    end
    vectors++;
    if (done_seen || bus_a.busy !== 1'b0) begin
      miscompares++;
      $display("FAIL abort_nodone: done_seen=%b busy=%b want 0 0", done_seen, bus_a.busy);
    end
  endtask

  task automatic test_back_to_back();
    int cyc;
    gut_tt = 4'b0000; // mismatch only at vector 3
    bus_a.start = 1'b1;
    cyc = 0;
    while (bus_a.done !== 1'b1 && cyc < 40) begin
      @(negedge clk);
      cyc++;
      bus_a.start = (cyc == 5); // re-pulse while busy
    end
    bus_a.start = 1'b0;
    vectors++;
    if (cyc != run_len(4, 4) || bus_a.err_count !== 3'd1 || bus_a.fail_vec !== 2'd3) begin
      miscompares++;
      $display("FAIL b2b_run: done after %0d err=%0d fvec=%0d want %0d err=1 fvec=3", cyc,
               bus_a.err_count, bus_a.fail_vec, run_len(4, 4));
    end
    bus_a.start = 1'b1; // sampled in the DONE cycle
    @(negedge clk);
    bus_a.start = 1'b0;
    vectors++;
    if (bus_a.busy !== 1'b0 || bus_a.vec_out !== 2'd0 || bus_a.err_count !== 3'd1) begin
      miscompares++;
      $display("FAIL b2b_done_start: busy=%b vec_out=%0d err=%0d want busy=0 vec_out=0 err=1",
               bus_a.busy, bus_a.vec_out, bus_a.err_count);
    end
    repeat (3) @(negedge clk);
    vectors++;
    if (bus_a.busy !== 1'b0) begin
      miscompares++;
      $display("FAIL b2b_idle: busy=%b want 0", bus_a.busy);
    end
    gut_tt = TT_AND2;
    bus_a.start = 1'b1;
    @(negedge clk);
    bus_a.start = 1'b0;
    vectors++;
    if (bus_a.busy !== 1'b1 || bus_a.err_count !== 3'd0 || bus_a.fail_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL b2b_restart: busy=%b err=%0d fv=%b want busy=1 err=0 fv=0", bus_a.busy,
               bus_a.err_count, bus_a.fail_valid);
    end
    cyc = 1;
    while (bus_a.done !== 1'b1 && cyc < 40) begin
      @(negedge clk);
      cyc++;
    end
    vectors++;
    if (cyc != run_len(4, 4) || bus_a.pass !== 1'b1) begin
      miscompares++;
      $display("FAIL b2b_second: done after %0d pass=%b want %0d pass=1", cyc, bus_a.pass,
               run_len(4, 4));
    end
    @(negedge clk);
  endtask

  task automatic test_async_reset();
    int cyc;
    gut_tt = 4'b0001; // vector 0 mismatches, so error state is non-zero before reset
    bus_a.start = 1'b1;
    repeat (8) begin
      @(negedge clk);
      bus_a.start = 1'b0;
    end
    #2;
    rst_n = 1'b0;
    #1;
    vectors++;
    if ({bus_a.vec_out, bus_a.busy, bus_a.done, bus_a.pass, bus_a.err_count, bus_a.fail_vec,
         bus_a.fail_valid} !== 10'd0) begin
      miscompares++;
      $display("FAIL async_reset: outputs=%b want all zero", {bus_a.vec_out, bus_a.busy,
               bus_a.done, bus_a.pass, bus_a.err_count, bus_a.fail_vec, bus_a.fail_valid});
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    gut_tt = TT_AND2;
    bus_a.start = 1'b1;
    cyc = 0;
    while (bus_a.done !== 1'b1 && cyc < 40) begin
      @(negedge clk);
      bus_a.start = 1'b0;
      cyc++;
    end
    bus_a.start = 1'b0;
    vectors++;
    if (cyc != run_len(4, 4) || bus_a.pass !== 1'b1 || bus_a.err_count !== 3'd0) begin
      miscompares++;
      $display("FAIL reset_rerun: done after %0d pass=%b err=%0d want %0d pass=1 err=0", cyc,
               bus_a.pass, bus_a.err_count, run_len(4, 4));
    end
    @(negedge clk);
  endtask

  task automatic test_or_table();
    int errs, fvec, cyc;
    bit fvalid, ok;
    model({12'd0, TT_AND2}, {12'd0, TT_OR2}, 4, errs, fvalid, fvec, ok);
    bus_o.start = 1'b1;
    cyc = 0;
    while (bus_o.done !== 1'b1 && cyc < 40) begin
      @(negedge clk);
      bus_o.start = 1'b0;
      cyc++;
    end
    bus_o.start = 1'b0;
    vectors++;
    if (cyc != run_len(4, 4)) begin
      miscompares++;
      $display("FAIL or_latency: done after %0d want %0d", cyc, run_len(4, 4));
    end
    vectors++;
    if (bus_o.err_count !== 3'(errs) || bus_o.fail_vec !== 2'(fvec) ||
        bus_o.fail_valid !== fvalid || bus_o.pass !== ok) begin
      miscompares++;
      $display("FAIL or_result: err=%0d fvec=%0d fv=%b pass=%b want err=%0d fvec=%0d fv=%b pass=%b",
               bus_o.err_count, bus_o.fail_vec, bus_o.fail_valid, bus_o.pass, errs, fvec, fvalid,
               ok);
    end
    @(negedge clk);
  endtask

  task automatic test_inverter();
    bus_i.start = 1'b1;
    @(negedge clk);
    bus_i.start = 1'b0;
    vectors++;
    if (bus_i.vec_out !== 1'b0 || bus_i.busy !== 1'b1) begin
      miscompares++;
      $display("FAIL inv_v0: vec_out=%b busy=%b want 0 1", bus_i.vec_out, bus_i.busy);
    end
    @(negedge clk);
    vectors++;
    if (bus_i.vec_out !== 1'b1 || bus_i.done !== 1'b0) begin
      miscompares++;
      $display("FAIL inv_v1: vec_out=%b done=%b want 1 0", bus_i.vec_out, bus_i.done);
    end
    @(negedge clk);
    vectors++;
    if (bus_i.done !== 1'b1 || bus_i.pass !== 1'b1 || bus_i.err_count !== 2'd0) begin
      miscompares++;
      $display("FAIL inv_done: done=%b pass=%b err=%0d want 1 1 0", bus_i.done, bus_i.pass,
               bus_i.err_count);
    end
    @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0;
    gut_tt = TT_AND2;
    bus_a.start = 1'b0;
    bus_a.abort = 1'b0;
    bus_o.start = 1'b0;
    bus_o.abort = 1'b0;
    bus_i.start = 1'b0;
    bus_i.abort = 1'b0;
    vectors = 0;
    miscompares = 0;
    test_reset();
    test_and_run();
    test_random();
    test_abort();
    test_back_to_back();
    test_async_reset();
    test_or_table();
    test_inverter();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
